// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter with a single outstanding transaction (IDLE/ISSUE/WAIT).
// Define ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mem_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  // requester 0 (hart)
  input  logic        i_rq0_valid,
  output logic        o_rq0_ready,
  input  logic [31:0] i_rq0_addr,
  input  logic        i_rq0_wen,
  input  logic [31:0] i_rq0_wdata,
  input  logic [3:0]  i_rq0_mask,
  output logic        o_rq0_rvalid,
  output logic [31:0] o_rq0_rdata,
  // requester 1 (aux)
  input  logic        i_rq1_valid,
  output logic        o_rq1_ready,
  input  logic [31:0] i_rq1_addr,
  input  logic        i_rq1_wen,
  input  logic [31:0] i_rq1_wdata,
  input  logic [3:0]  i_rq1_mask,
  output logic        o_rq1_rvalid,
  output logic [31:0] o_rq1_rdata,
  // memory side
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_mask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 4;
  localparam int unsigned WA = AW - 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [WA-1:0]   addr_q,  addr_d;
  logic            wen_q,   wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [MW-1:0]   mask_q,  mask_d;

  logic            winner;
  logic            gnt0, gnt1;
  logic            rsp0, rsp1;
  logic            issue;

`ifndef ARB_FIXED_PRIO_EN
  logic            ptr_q, ptr_d;
`endif

  // Winner selection: a lone request always wins; ties go to the favoured side.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    winner = ~i_rq0_valid;
`else
    winner = (i_rq0_valid && i_rq1_valid) ? ptr_q : i_rq1_valid;
`endif
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    wen_d   = wen_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
`ifndef ARB_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rsp0    = 1'b0;
    rsp1    = 1'b0;
    issue   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_rq0_valid || i_rq1_valid) begin
          state_d = S_ISSUE;
          owner_d = winner;
          gnt0    = ~winner;
          gnt1    = winner;
`ifndef ARB_FIXED_PRIO_EN
          ptr_d   = ~winner;
`endif
          if (winner) begin
            addr_d  = i_rq1_addr[AW-1:2];
            wen_d   = i_rq1_wen;
            wdata_d = i_rq1_wdata;
            mask_d  = i_rq1_mask;
          end else begin
            addr_d  = i_rq0_addr[AW-1:2];
            wen_d   = i_rq0_wen;
            wdata_d = i_rq0_wdata;
            mask_d  = i_rq0_mask;
          end
        end
      end
      S_ISSUE: begin
        issue = 1'b1;
        if (i_mem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          state_d = S_IDLE;
          rsp0    = ~owner_q;
          rsp1    = owner_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end

`ifndef ARB_FIXED_PRIO_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Ready and response strobes are combinational, so they are masked during reset.
  assign o_rq0_ready  = gnt0 & ~i_rst;
  assign o_rq1_ready  = gnt1 & ~i_rst;
  assign o_rq0_rvalid = rsp0 & ~i_rst;
  assign o_rq1_rvalid = rsp1 & ~i_rst;
  assign o_rq0_rdata  = o_rq0_rvalid ? i_mem_rdata : '0;
  assign o_rq1_rdata  = o_rq1_rvalid ? i_mem_rdata : '0;

  assign o_mem_valid  = issue;
  assign o_mem_addr   = issue ? {addr_q, 2'b00} : '0;
  assign o_mem_ren    = issue & ~wen_q;
  assign o_mem_wen    = issue & wen_q;
  assign o_mem_wdata  = issue ? wdata_q : '0;
  assign o_mem_mask   = issue ? mask_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (round-robin or ARB_FIXED_PRIO_EN build).
module tb_mem_arbiter;

  logic        i_clk;
  logic        i_rst;
  logic        i_rq0_valid, i_rq1_valid;
  logic        o_rq0_ready, o_rq1_ready;
  logic [31:0] i_rq0_addr,  i_rq1_addr;
  logic        i_rq0_wen,   i_rq1_wen;
  logic [31:0] i_rq0_wdata, i_rq1_wdata;
  logic [3:0]  i_rq0_mask,  i_rq1_mask;
  logic        o_rq0_rvalid, o_rq1_rvalid;
  logic [31:0] o_rq0_rdata,  o_rq1_rdata;
  logic        o_mem_valid;
  logic        i_mem_ready;
  logic [31:0] o_mem_addr;
  logic        o_mem_ren, o_mem_wen;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  mem_arbiter dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_rq0_valid  (i_rq0_valid),
    .o_rq0_ready  (o_rq0_ready),
    .i_rq0_addr   (i_rq0_addr),
    .i_rq0_wen    (i_rq0_wen),
    .i_rq0_wdata  (i_rq0_wdata),
    .i_rq0_mask   (i_rq0_mask),
    .o_rq0_rvalid (o_rq0_rvalid),
    .o_rq0_rdata  (o_rq0_rdata),
    .i_rq1_valid  (i_rq1_valid),
    .o_rq1_ready  (o_rq1_ready),
    .i_rq1_addr   (i_rq1_addr),
    .i_rq1_wen    (i_rq1_wen),
    .i_rq1_wdata  (i_rq1_wdata),
    .i_rq1_mask   (i_rq1_mask),
    .o_rq1_rvalid (o_rq1_rvalid),
    .o_rq1_rdata  (o_rq1_rdata),
    .o_mem_valid  (o_mem_valid),
    .i_mem_ready  (i_mem_ready),
    .o_mem_addr   (o_mem_addr),
    .o_mem_ren    (o_mem_ren),
    .o_mem_wen    (o_mem_wen),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_rq0_valid = 1'b0; i_rq0_addr = '0; i_rq0_wen = 1'b0; i_rq0_wdata = '0; i_rq0_mask = '0;
    i_rq1_valid = 1'b0; i_rq1_addr = '0; i_rq1_wen = 1'b0; i_rq1_wdata = '0; i_rq1_mask = '0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},    32'({o_rq1_ready, o_rq0_ready}), 32'd0);
    check({tag, "_rvalid"}, 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd0);
    check({tag, "_rdata0"}, o_rq0_rdata, 32'd0);
    check({tag, "_rdata1"}, o_rq1_rdata, 32'd0);
    check({tag, "_memv"},   32'({o_mem_valid, o_mem_ren, o_mem_wen}), 32'd0);
    check({tag, "_maddr"},  o_mem_addr, 32'd0);
    check({tag, "_mwdata"}, o_mem_wdata, 32'd0);
    check({tag, "_mmask"},  32'(o_mem_mask), 32'd0);
  endtask

  logic [1:0] exp_gnt [4];

  initial begin
    // Reset: outputs stay zero even with requests and a response strobe pending
    clear_inputs();
    i_rst = 1'b1;
    i_rq0_valid = 1'b1;
    i_rq1_valid = 1'b1;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'hFFFF_FFFF;
    #2;
    check_all_zero("reset");
    tick();
    check_all_zero("reset_held");
    clear_inputs();
    i_rst = 1'b0;

    // rq0 read, memory ready at once, response one cycle later
    i_rq0_valid = 1'b1; i_rq0_addr = 32'h0000_1002; i_rq0_wen = 1'b0; i_rq0_mask = 4'b1100;
    #1;
    check("t1_grant", 32'({o_rq1_ready, o_rq0_ready}), 32'd1);
    check("t1_idle_memv", 32'(o_mem_valid), 32'd0);
    tick();
    i_rq0_valid = 1'b0;
    i_mem_ready = 1'b1;
    #1;
    check("t1_memv", 32'(o_mem_valid), 32'd1);
    check("t1_addr", o_mem_addr, 32'h0000_1000);
    check("t1_ren_wen", 32'({o_mem_ren, o_mem_wen}), 32'd2);
    check("t1_mask", 32'(o_mem_mask), 32'hC);
    check("t1_issue_rdy", 32'({o_rq1_ready, o_rq0_ready}), 32'd0);
    tick();
    i_mem_ready = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'hABCD_0000;
    #1;
    check("t1_rvalid", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd1);
    check("t1_rdata0", o_rq0_rdata, 32'hABCD_0000);
    check("t1_rdata1", o_rq1_rdata, 32'd0);
    check("t1_wait_memv", 32'(o_mem_valid), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    #1;
    check("t1_done_rvalid", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd0);

    // Both requesters valid continuously after reset
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    if (FIXED) begin
      exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b01;
    end else begin
      exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01; exp_gnt[3] = 2'b10;
    end
    i_rq0_valid = 1'b1; i_rq0_addr = 32'h0000_0100;
    i_rq1_valid = 1'b1; i_rq1_addr = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr_grant%0d", i), 32'({o_rq1_ready, o_rq0_ready}), 32'(exp_gnt[i]));
      tick();
      i_mem_ready = 1'b1;
      #1;
      check($sformatf("rr_addr%0d", i), o_mem_addr, exp_gnt[i][1] ? 32'h0000_0200 : 32'h0000_0100);
      check($sformatf("rr_issue_rdy%0d", i), 32'({o_rq1_ready, o_rq0_ready}), 32'd0);
      tick();
      i_mem_ready = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata = 32'(i + 16);
      #1;
      check($sformatf("rr_rsp%0d", i), 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'(exp_gnt[i]));
      tick();
      i_mem_rvalid = 1'b0;
    end
    i_rq0_valid = 1'b0;
    i_rq1_valid = 1'b0;

    // rq1 write with memory stalling for 4 cycles; inputs scrambled after accept
    i_rq1_valid = 1'b1; i_rq1_addr = 32'h0000_2003; i_rq1_wen = 1'b1;
    i_rq1_wdata = 32'h5500_0000; i_rq1_mask = 4'b1000;
    #1;
    check("t3_grant", 32'({o_rq1_ready, o_rq0_ready}), 32'd2);
    tick();
    i_rq1_valid = 1'b0; i_rq1_addr = 32'hFFFF_FFFF; i_rq1_wen = 1'b0;
    i_rq1_wdata = 32'h1111_1111; i_rq1_mask = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t3_stall_addr%0d", i), o_mem_addr, 32'h0000_2000);
      check($sformatf("t3_stall_wdata%0d", i), o_mem_wdata, 32'h5500_0000);
      check($sformatf("t3_stall_ctl%0d", i), 32'({o_mem_valid, o_mem_ren, o_mem_wen, o_mem_mask}), 32'h4_8 + 32'h10);
      tick();
    end
    i_mem_ready = 1'b1;
    #1;
    check("t3_ready_memv", 32'(o_mem_valid), 32'd1);
    tick();
    i_mem_ready = 1'b0;
    #1;
    check("t3_wait_norsp", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd0);
    check("t3_wait_memv", 32'({o_mem_valid, o_mem_ren, o_mem_wen}), 32'd0);
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'h1234_5678;
    #1;
    check("t3_ack", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd2);
    check("t3_ack_rdata1", o_rq1_rdata, 32'h1234_5678);
    check("t3_ack_rdata0", o_rq0_rdata, 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    #1;
    check("t3_post_rsp", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd0);

    // Reset asserted in WAIT, then a stray response
    clear_inputs();
    i_rq0_valid = 1'b1; i_rq0_addr = 32'h0000_3000;
    tick();
    i_rq0_valid = 1'b0;
    i_mem_ready = 1'b1;
    tick();
    i_mem_ready = 1'b0;
    i_rst = 1'b1;
    #1;
    check_all_zero("t4_rst");
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'hCAFE_F00D;
    i_rq0_valid = 1'b1;
    #1;
    check_all_zero("t4_stray");
    tick();
    i_rst = 1'b0;
    i_rq0_valid = 1'b0;
    #1;
    check("t4_idle_norsp", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd0);
    check("t4_idle_memv", 32'(o_mem_valid), 32'd0);
    i_rq1_valid = 1'b1;
    #1;
    check("t4_idle_grant", 32'({o_rq1_ready, o_rq0_ready}), 32'd2);
    i_rq1_valid = 1'b0;
    i_mem_rvalid = 1'b0;
    tick();
    check("t4_forfeit_memv", 32'(o_mem_valid), 32'd0);

    // Stray rvalid in IDLE, stray ready in WAIT
    i_mem_rvalid = 1'b1;
    i_mem_ready = 1'b1;
    #1;
    check("t5_idle_stray_rsp", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd0);
    check("t5_idle_stray_memv", 32'(o_mem_valid), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("t5_still_idle", 32'(o_mem_valid), 32'd0);
    i_rq1_valid = 1'b1; i_rq1_addr = 32'h0000_4008;
    #1;
    check("t5_grant", 32'({o_rq1_ready, o_rq0_ready}), 32'd2);
    tick();
    i_rq1_valid = 1'b0;
    #1;
    check("t5_issue_addr", o_mem_addr, 32'h0000_4008);
    tick();
    i_mem_ready = 1'b1;
    tick();
    i_rq0_valid = 1'b1;
    #1;
    check("t5_wait_stray_rdy", 32'({o_rq1_ready, o_rq0_ready}), 32'd0);
    check("t5_wait_stray_rsp", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd0);
    check("t5_wait_stray_memv", 32'(o_mem_valid), 32'd0);
    tick();
    i_mem_ready = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("t5_rsp", 32'({o_rq1_rvalid, o_rq0_rvalid}), 32'd2);
    check("t5_rsp_rdata1", o_rq1_rdata, 32'hDEAD_BEEF);
    check("t5_rsp_nordy", 32'({o_rq1_ready, o_rq0_ready}), 32'd0);
    tick();
    i_mem_rvalid = 1'b0;
    #1;
    check("t5_back_idle", 32'({o_rq1_ready, o_rq0_ready}), 32'd1);
    i_rq0_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have no parameters; all address and data paths are fixed at 32 bits and masks at 4 bits.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have, for each requester N in {0 (hart), 1 (aux)}, port i_rqN_valid, input, 1, request pending.
REQ-005 SHALL have, for each N, port o_rqN_ready, output, 1, request accepted this cycle.
REQ-006 SHALL have, for each N, port i_rqN_addr, input, 32, byte address.
REQ-007 SHALL have, for each N, port i_rqN_wen, input, 1, 1 for write, 0 for read.
REQ-008 SHALL have, for each N, port i_rqN_wdata, input, 32, write data.
REQ-009 SHALL have, for each N, port i_rqN_mask, input, 4, byte-lane mask.
REQ-010 SHALL have, for each N, port o_rqN_rvalid, output, 1, response strobe.
REQ-011 SHALL have, for each N, port o_rqN_rdata, output, 32, read data.
REQ-012 SHALL have memory-side ports o_mem_valid (output, 1), i_mem_ready (input, 1), o_mem_addr (output, 32, word-aligned), o_mem_ren (output, 1), o_mem_wen (output, 1), o_mem_wdata (output, 32), o_mem_mask (output, 4), i_mem_rvalid (input, 1, response or write acknowledge) and i_mem_rdata (input, 32).

Function
REQ-013 SHALL implement the FSM states IDLE, ISSUE and WAIT.
REQ-014 IDLE: if any i_rqN_valid, SHALL select a winner, assert its o_rqN_ready for that cycle, latch addr/wen/wdata/mask and owner, then go to ISSUE; otherwise SHALL stay in IDLE.
REQ-015 SHALL never assert more than one o_rqN_ready per cycle, and SHALL assert it only in IDLE.
REQ-016 ISSUE: SHALL assert o_mem_valid with the latched fields; o_mem_addr SHALL equal latched addr with bits [1:0] forced to 0.
REQ-017 ISSUE: o_mem_ren SHALL equal ~wen and o_mem_wen SHALL equal wen; both SHALL be 0 outside ISSUE and SHALL never both be 1.
REQ-018 ISSUE: request fields SHALL hold stable until i_mem_ready=1, then the FSM SHALL go to WAIT.
REQ-019 WAIT: on i_mem_rvalid=1, SHALL combinationally drive the owner's o_rqN_rvalid=1 and o_rqN_rdata=i_mem_rdata, then return to IDLE.
REQ-020 The non-owner's o_rqN_rvalid SHALL be 0, and o_rqN_rdata SHALL be 0 whenever o_rqN_rvalid=0.
REQ-021 SHALL ignore i_mem_ready outside ISSUE and i_mem_rvalid outside WAIT.
REQ-022 Minimum transaction length SHALL be 3 cycles (accept, issue, response); only one transaction SHALL be outstanding.
REQ-023 Round-robin arbitration: a 1-bit priority pointer SHALL name the favoured requester.
REQ-024 Round-robin arbitration: on simultaneous valid, the favoured requester SHALL win; after every grant the pointer SHALL point to the non-granted requester.
REQ-025 Round-robin arbitration: a lone valid SHALL always win regardless of the pointer.
REQ-026 A requester deasserting valid before ready SHALL forfeit without side effects.

Reset
REQ-027 While i_rst=1, SHALL hold state at IDLE, the pointer at 0 and the latched fields at 0.
REQ-028 While i_rst=1, all outputs (o_rqN_ready, o_rqN_rvalid, o_rqN_rdata, o_mem_*) SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL drop the transaction with no o_rqN_rvalid produced.
REQ-030 The first grant after reset release SHALL come no earlier than the first rising edge with i_rst=0.

Configuration
REQ-031 When ARB_FIXED_PRIO_EN is defined, requester 0 SHALL always win simultaneous requests and the pointer SHALL be absent.
REQ-032 When ARB_FIXED_PRIO_EN is undefined, the round-robin of REQ-023 to REQ-025 SHALL apply.

Verification
REQ-033 Bench SHALL cover: rq0 read addr=0x00001002 mask=0b1100, memory ready at once, rdata=0xABCD0000 one cycle later -> o_mem_addr=0x00001000, o_mem_ren=1, o_rq0_rvalid=1 with rdata 0xABCD0000 on cycle 3.
REQ-034 Bench SHALL cover: both valid continuously after reset, round-robin -> grant order 0,1,0,1; with ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-035 Bench SHALL cover: rq1 write addr=0x00002003 wdata=0x55000000 mask=0b1000, i_mem_ready low for 4 cycles -> fields stable 4 cycles, o_mem_wen=1, o_mem_ren=0, o_rq1_rvalid pulses on ack.
REQ-036 Bench SHALL cover: i_rst asserted while in WAIT, then a stray i_mem_rvalid -> all outputs 0 immediately, no o_rqN_rvalid, FSM IDLE.
REQ-037 Bench SHALL cover: stray i_mem_rvalid=1 in IDLE and i_mem_ready=1 in WAIT -> no state change, no response strobes.
